regfile_wr_arbiter: RTL and testbench
=====================================

// Module: regfile_wr_arbiter
// PURPOSE
//  Shares the single register-file write port (RegWrite/W_Addr/W_Data) between two requesters:
//  A = pipeline writeback, B = multi-cycle unit (mul/div, loader).
//  Fixed priority to A with a starvation guard for B. Writes reach the port one cycle after acceptance.
//  Optional clear sequencer zeroes x1..x31 on command without asserting rst.
// PARAMETERS
//  N          32  data width, matches register file width
//  STARVE_MAX 4   consecutive stalled B cycles before B is forced ahead of A (>=1)
// PORTS
//  clk        in   1      rising-edge clock, single clock domain
//  rst        in   1      synchronous, active-high reset
//  a_valid    in   1      A has a write pending
//  a_ready    out  1      A write accepted this cycle (combinational)
//  a_addr     in   5      A destination register
//  a_data     in   N      A write data
//  b_valid    in   1      B has a write pending
//  b_ready    out  1      B write accepted this cycle (combinational)
//  b_addr     in   5      B destination register
//  b_data     in   N      B write data
//  clr_start  in   1      pulse: start clear sequence (RF_CLEAR_EN only)
//  clr_busy   out  1      clear sequence in progress
//  clr_done   out  1      one-cycle pulse after the last clear write
//  rf_we      out  1      to register file RegWrite (registered)
//  rf_waddr   out  5      to register file W_Addr (registered)
//  rf_wdata   out  N      to register file W_Data (registered)
//  conflict   out  1      a_valid & b_valid in same cycle, not clearing (combinational)
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): rf_we=0, rf_waddr=0, rf_wdata=0, clr_busy=0, clr_done=0,
//    starve_cnt=0, state=ARB. Reset mid-clear aborts the clear; no clr_done pulse.
//  - Handshake: transfer occurs when valid&ready in the same cycle. ready never asserts without valid.
//    At most one of a_ready/b_ready high per cycle.
//  - State ARB: grant rules, in order:
//    1. clr_start=1 -> no grant; state=CLEAR next cycle.
//    2. b_valid & starve_cnt==STARVE_MAX -> B granted.
//    3. a_valid -> A granted.
//    4. b_valid -> B granted.
//  - starve_cnt: +1 each ARB cycle with b_valid & !b_ready (saturates at STARVE_MAX).
//    Cleared to 0 on a B grant or when b_valid=0. Held during CLEAR.
//  - Latency: a write granted in cycle t drives rf_we=1 with its addr/data in cycle t+1.
//    rf_we=0 in any cycle after no grant.
//  - Writes to x0 are accepted (ready=1) but produce rf_we=0; rf_waddr/rf_wdata still update.
//  - Same-address A/B collision: A goes first, B retries. Ordering is the requesters' responsibility.
//  - State CLEAR: a_ready=b_ready=0 and clr_busy=1.
//    Issues rf_we=1, rf_wdata=0 for rf_waddr=1,2,...,31 on consecutive cycles (31 writes).
//    After addr 31 is issued: clr_done=1 for one cycle, clr_busy=0, state returns to ARB.
//    Clear latency: clr_start at cycle t -> first clear write at t+1, clr_done at t+32.
//  - clr_start while in CLEAR is ignored; the sequence is not restarted.
//  - conflict is forced to 0 in CLEAR.
// CONFIGURATION
//  RF_CLEAR_EN defined:
//    CLEAR state, clear counter and clr_start/clr_busy/clr_done behave as above.
//  RF_CLEAR_EN undefined:
//    No CLEAR state or counter. clr_start is ignored; clr_busy=0 and clr_done=0 always.
//    Grant rule 1 is removed. Ports remain so the module interface is unchanged.
// TESTING
//  1. Reset: rst=1 for 2 cycles with a_valid=b_valid=1 -> rf_we=0, a_ready=b_ready=0 throughout.
//  2. Single A: a_valid=1, a_addr=5, a_data=0xDEADBEEF for 1 cycle -> a_ready=1;
//     next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
//  3. Starvation: a_valid=1 continuous, b_valid=1 (addr 7, data 0x11) -> B stalls 4 cycles;
//     5th cycle b_ready=1, a_ready=0; conflict=1 all 5 cycles; starve_cnt then 0.
//  4. x0 drop: b_valid=1, b_addr=0, b_data=0x55 -> b_ready=1; next cycle rf_we=0.
//  5. Clear (RF_CLEAR_EN): clr_start pulse with a_valid=1 -> a_ready=0 for 32 cycles;
//     rf_waddr 1..31 with rf_wdata=0; clr_done at t+32; a_ready=1 at t+32.
//  6. Reset mid-clear: rst at clear write to addr 10 -> next cycle clr_busy=0, rf_we=0,
//     no clr_done pulse, state ARB.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: A (writeback) has priority, B (multi-cycle unit) gets a starvation guard.
// Define RF_CLEAR_EN to build the optional x1..x31 clear sequencer.
module regfile_wr_arbiter #(
  parameter int N          = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [4:0]   a_addr,
  input  logic [N-1:0] a_data,
  input  logic         b_valid,
  output logic         b_ready,
  input  logic [4:0]   b_addr,
  input  logic [N-1:0] b_data,
  input  logic         clr_start,
  output logic         clr_busy,
  output logic         clr_done,
  output logic         rf_we,
  output logic [4:0]   rf_waddr,
  output logic [N-1:0] rf_wdata,
  output logic         conflict
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic          in_arb;
  logic          clr_go;
  logic          clr_issue;
  logic [4:0]    clr_addr;
  logic [SW-1:0] starve_cnt;
  logic          b_force;
  logic          grant_a;
  logic          grant_b;

`ifdef RF_CLEAR_EN
  typedef enum logic {ARB, CLEAR} state_t;

  state_t     state_q;
  state_t     state_d;
  logic [4:0] clr_cnt;
  logic       clr_last;

  assign in_arb    = (state_q == ARB);
  assign clr_go    = in_arb && clr_start;
  assign clr_busy  = (state_q == CLEAR);
  // clr_cnt holds the address currently on the port; 31 is the final clear write.
  assign clr_issue = clr_go || (state_q == CLEAR && clr_cnt != 5'd31);
  assign clr_addr  = clr_go ? 5'd1 : clr_cnt + 5'd1;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d  = state_q;
    clr_last = 1'b0;
    unique case (state_q)
      ARB:   if (clr_start) state_d = CLEAR;
      CLEAR: if (clr_cnt == 5'd31) begin
               state_d  = ARB;
               clr_last = 1'b1;
             end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB;
      clr_cnt  <= 5'd0;
      clr_done <= 1'b0;
    end else begin
      state_q  <= state_d;
      clr_done <= clr_last;
      if (clr_issue) clr_cnt <= clr_addr;
    end
  end
`else
  logic unused_clr_start;

  assign unused_clr_start = clr_start;
  assign in_arb    = 1'b1;
  assign clr_go    = 1'b0;
  assign clr_issue = 1'b0;
  assign clr_addr  = 5'd0;
  assign clr_busy  = 1'b0;
  assign clr_done  = 1'b0;
`endif

  assign b_force = b_valid && (starve_cnt == STARVE_LIM);

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst && in_arb && !clr_go) begin
      if (b_force)      grant_b = 1'b1;
      else if (a_valid) grant_a = 1'b1;
      else if (b_valid) grant_b = 1'b1;
    end
  end

  assign a_ready  = grant_a;
  assign b_ready  = grant_b;
  assign conflict = a_valid && b_valid && in_arb;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      starve_cnt <= '0;
    end else if (in_arb) begin
      if (!b_valid || grant_b)        starve_cnt <= '0;
      else if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // x0 writes are consumed but never reach the register file; addr/data still track the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= '0;
    end else if (grant_a) begin
      rf_we    <= (a_addr != 5'd0);
      rf_waddr <= a_addr;
      rf_wdata <= a_data;
    end else if (grant_b) begin
      rf_we    <= (b_addr != 5'd0);
      rf_waddr <= b_addr;
      rf_wdata <= b_data;
    end else if (clr_issue) begin
      rf_we    <= 1'b1;
      rf_waddr <= clr_addr;
      rf_wdata <= '0;
    end else begin
      rf_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: expected port writes queued at drive time, popped after the edge.
module tb_regfile_wr_arbiter;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, clr_start;
  logic        a_ready, b_ready, clr_busy, clr_done, conflict;
  logic [4:0]  a_addr, b_addr, rf_waddr;
  logic [31:0] a_data, b_data, rf_wdata;
  logic        rf_we;

  int  total  = 0;
  int  passed = 0;
  wr_t sb[$];
  wr_t model;

  regfile_wr_arbiter #(.N(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .conflict(conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  function automatic wr_t wr(input logic [4:0] ad, input logic [31:0] d);
    wr_t w;
    w.we   = (ad != 5'd0);
    w.addr = ad;
    w.data = d;
    return w;
  endfunction

  function automatic wr_t idle();
    wr_t w;
    w.we   = 1'b0;
    w.addr = model.addr;
    w.data = model.data;
    return w;
  endfunction

  // One clock: combinational outputs checked at negedge, registered write checked just after posedge.
  task automatic step(input logic ea, input logic eb, input logic ec, input logic ebusy,
                      input logic edone, input wr_t exp, input string tag);
    wr_t got;
    @(negedge clk);
    chk({tag, " a_ready"},  32'(a_ready),  32'(ea));
    chk({tag, " b_ready"},  32'(b_ready),  32'(eb));
    chk({tag, " conflict"}, 32'(conflict), 32'(ec));
    chk({tag, " clr_busy"}, 32'(clr_busy), 32'(ebusy));
    chk({tag, " clr_done"}, 32'(clr_done), 32'(edone));
    sb.push_back(exp);
    model = exp;
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({tag, " rf_we"},    32'(rf_we),    32'(got.we));
    chk({tag, " rf_waddr"}, 32'(rf_waddr), 32'(got.addr));
    chk({tag, " rf_wdata"}, rf_wdata,      got.data);
  endtask

  initial begin
    rst = 1'b1; clr_start = 1'b0;
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hAAAA_0000;
    b_valid = 1'b1; b_addr = 5'd4; b_data = 32'hBBBB_0000;
    model = '0;

    // Reset with both requesters pending.
    step(0, 0, 1, 0, 0, '0, "reset0");
    step(0, 0, 1, 0, 0, '0, "reset1");
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    step(0, 0, 0, 0, 0, idle(), "idle");

    // Single A write.
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEAD_BEEF;
    step(1, 0, 0, 0, 0, wr(5'd5, 32'hDEAD_BEEF), "single_a");
    a_valid = 1'b0;
    step(0, 0, 0, 0, 0, idle(), "single_a_after");

    // Starvation: B stalls 4 cycles, then is forced ahead of A.
    a_valid = 1'b1; a_addr = 5'd3;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h11;
    for (int i = 0; i < 4; i++) begin
      a_data = 32'(100 + i);
      step(1, 0, 1, 0, 0, wr(a_addr, a_data), "starve_stall");
    end
    step(0, 1, 1, 0, 0, wr(5'd7, 32'h11), "starve_force");

    // Counter restarts after the forced grant: another full 4-cycle stall.
    b_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      a_data = 32'(200 + i);
      step(1, 0, 1, 0, 0, wr(a_addr, a_data), "starve2_stall");
    end
    step(0, 1, 1, 0, 0, wr(5'd7, 32'h22), "starve2_force");

    // Dropping b_valid clears the counter.
    b_data = 32'h33;
    for (int i = 0; i < 2; i++) begin
      a_data = 32'(300 + i);
      step(1, 0, 1, 0, 0, wr(a_addr, a_data), "drop_stall");
    end
    b_valid = 1'b0; a_data = 32'h0000_0400;
    step(1, 0, 0, 0, 0, wr(a_addr, a_data), "drop_gap");
    b_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_data = 32'(500 + i);
      step(1, 0, 1, 0, 0, wr(a_addr, a_data), "drop_restall");
    end
    step(0, 1, 1, 0, 0, wr(5'd7, 32'h33), "drop_force");

    // x0 writes: accepted, no register-file write.
    a_valid = 1'b0; b_addr = 5'd0; b_data = 32'h55;
    step(0, 1, 0, 0, 0, wr(5'd0, 32'h55), "b_x0");
    b_addr = 5'd9; b_data = 32'h99;
    step(0, 1, 0, 0, 0, wr(5'd9, 32'h99), "b_only");
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'h77;
    step(1, 0, 1, 0, 0, wr(5'd0, 32'h77), "a_x0");
    b_valid = 1'b0; a_addr = 5'd12; a_data = 32'hC0FF_EE00;

`ifdef RF_CLEAR_EN
    // Clear sequence, with a redundant clr_start mid-sequence and B pending during CLEAR.
    clr_start = 1'b1;
    step(0, 0, 0, 0, 0, wr(5'd1, 32'h0), "clr_start");
    clr_start = 1'b0; b_valid = 1'b1; b_addr = 5'd8; b_data = 32'h88;
    for (int k = 2; k <= 31; k++) begin
      clr_start = (k == 6);
      step(0, 0, 0, 1, 0, wr(5'(k), 32'h0), "clr_seq");
    end
    clr_start = 1'b0;
    step(0, 0, 0, 1, 0, idle(), "clr_last");
    step(1, 0, 1, 0, 1, wr(5'd12, 32'hC0FF_EE00), "clr_done");
    b_valid = 1'b0;
    step(1, 0, 0, 0, 0, wr(5'd12, 32'hC0FF_EE00), "clr_after");

    // Reset while address 10 is on the port aborts the clear.
    clr_start = 1'b1;
    step(0, 0, 0, 0, 0, wr(5'd1, 32'h0), "abort_start");
    clr_start = 1'b0;
    for (int k = 2; k <= 10; k++) step(0, 0, 0, 1, 0, wr(5'(k), 32'h0), "abort_seq");
    rst = 1'b1;
    step(0, 0, 0, 1, 0, '0, "abort_rst");
    rst = 1'b0;
    step(1, 0, 0, 0, 0, wr(5'd12, 32'hC0FF_EE00), "abort_arb");
    step(1, 0, 0, 0, 0, wr(5'd12, 32'hC0FF_EE00), "abort_nodone");
`else
    // Without the clear feature, clr_start has no effect.
    clr_start = 1'b1;
    step(1, 0, 0, 0, 0, wr(5'd12, 32'hC0FF_EE00), "noclr_start");
    clr_start = 1'b0; a_data = 32'h1234_5678;
    step(1, 0, 0, 0, 0, wr(5'd12, 32'h1234_5678), "noclr_after");
`endif

    a_valid = 1'b0;
    step(0, 0, 0, 0, 0, idle(), "final_idle");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
